// File: rtl/id_exe_pipe_stage_if.sv
// rtl/id_exe_pipe_stage_if.sv - valid/ready handshake and decoded-instruction payload bundle
interface id_exe_pipe_stage_if #(
    parameter int REG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int IMM_A_W = 19,
    parameter int IMM_B_W = 26
);
    logic               valid;
    logic               ready;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [DATA_W-1:0]  d1;
    logic [DATA_W-1:0]  d2;
    logic [IMM_A_W-1:0] imm_a;
    logic [IMM_B_W-1:0] imm_b;

    modport master (
        output valid, rd, rs1, rs2, d1, d2, imm_a, imm_b,
        input  ready
    );

    modport slave (
        input  valid, rd, rs1, rs2, d1, d2, imm_a, imm_b,
        output ready
    );
endinterface

// File: rtl/id_exe_pipe_stage.sv
// rtl/id_exe_pipe_stage.sv - ID->EXE stage register with flush and stall counter; ID_EXE_SKID_EN adds a skid entry
module id_exe_pipe_stage #(
    parameter int REG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int IMM_A_W = 19,
    parameter int IMM_B_W = 26,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    id_exe_pipe_stage_if.slave  in_if,
    id_exe_pipe_stage_if.master out_if,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W = 3 * REG_W + 2 * DATA_W + IMM_A_W + IMM_B_W;

`ifdef ID_EXE_SKID_EN
    // bit0 = main entry valid, bit1 = skid entry valid
    typedef enum logic [1:0] {EMPTY = 2'b00, FULL = 2'b01, SKID = 2'b11} state_t;
`else
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] m_q;
    logic             xfer_in;
    logic             xfer_out;
    logic             m_load_in;

    assign in_pay = {in_if.rd, in_if.rs1, in_if.rs2, in_if.d1, in_if.d2, in_if.imm_a, in_if.imm_b};
    assign {out_if.rd, out_if.rs1, out_if.rs2, out_if.d1, out_if.d2, out_if.imm_a, out_if.imm_b} = m_q;

    assign xfer_in  = in_if.valid && in_if.ready;
    assign xfer_out = out_if.valid && out_if.ready;

`ifdef ID_EXE_SKID_EN
    logic [PAY_W-1:0] s_q;
    logic             m_load_s;
    logic             s_load;

    assign out_if.valid = state_q[0];
    assign in_if.ready  = !state_q[1];

    always_comb begin
        state_d   = state_q;
        m_load_in = 1'b0;
        m_load_s  = 1'b0;
        s_load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    state_d   = FULL;
                    m_load_in = 1'b1;
                end
            end
            FULL: begin
                if (xfer_in && xfer_out) begin
                    m_load_in = 1'b1;
                end else if (xfer_in) begin
                    state_d = SKID;
                    s_load  = 1'b1;
                end else if (xfer_out) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (xfer_out) begin
                    state_d  = FULL;
                    m_load_s = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush drops everything in flight, including the instruction arriving now
        if (flush) begin
            state_d   = EMPTY;
            m_load_in = 1'b0;
            m_load_s  = 1'b0;
            s_load    = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
        end else if (s_load) begin
            s_q <= in_pay;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
        end else if (m_load_in) begin
            m_q <= in_pay;
        end else if (m_load_s) begin
            m_q <= s_q;
        end
    end
`else
    assign out_if.valid = (state_q == FULL);
    // single entry: can refill in the same cycle the consumer drains it
    assign in_if.ready  = out_if.ready || !out_if.valid;

    always_comb begin
        state_d   = state_q;
        m_load_in = 1'b0;
        case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    state_d   = FULL;
                    m_load_in = 1'b1;
                end
            end
            FULL: begin
                if (xfer_in) begin
                    m_load_in = 1'b1;
                end else if (xfer_out) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d   = EMPTY;
            m_load_in = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
        end else if (m_load_in) begin
            m_q <= in_pay;
        end
    end
`endif

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_if.valid && !out_if.ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_pipe_stage.sv
// tb/tb_id_exe_pipe_stage.sv - directed self-checking bench for id_exe_pipe_stage
module tb_id_exe_pipe_stage;

`ifdef ID_EXE_SKID_EN
    localparam bit SKID_BUILD = 1'b1;
`else
    localparam bit SKID_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic flush_w;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_exe_pipe_stage_if ri ();
    id_exe_pipe_stage_if ro ();
    id_exe_pipe_stage_if #(.DATA_W(64), .IMM_B_W(30)) wi ();
    id_exe_pipe_stage_if #(.DATA_W(64), .IMM_B_W(30)) wo ();

    id_exe_pipe_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_if     (ri),
        .out_if    (ro),
        .stall_cnt (stall_cnt)
    );

    id_exe_pipe_stage #(.DATA_W(64), .IMM_B_W(30), .CNT_W(4)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_w),
        .in_if     (wi),
        .out_if    (wo),
        .stall_cnt (stall_cnt_w)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        flush_w = 1'b0;
        ri.valid = 1'b0; ri.rd = '0; ri.rs1 = '0; ri.rs2 = '0;
        ri.d1 = '0; ri.d2 = '0; ri.imm_a = '0; ri.imm_b = '0;
        ro.ready = 1'b0;
        wi.valid = 1'b0; wi.rd = '0; wi.rs1 = '0; wi.rs2 = '0;
        wi.d1 = '0; wi.d2 = '0; wi.imm_a = '0; wi.imm_b = '0;
        wo.ready = 1'b0;

        #3;
        check("rst_out_valid", ro.valid, 0);
        check("rst_in_ready", ri.ready, 1);
        check("rst_stall", stall_cnt, 0);
        check("rst_out_rd", ro.rd, 0);
        check("rst_out_d1", ro.d1, 0);
        check("rst_out_imm_b", ro.imm_b, 0);
        check("rst_w_valid", wo.valid, 0);
        check("rst_w_stall", stall_cnt_w, 0);
        #9;
        rst_n = 1'b1;

        // streaming 1..8 with the consumer always ready
        ri.valid = 1'b1;
        ro.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            ri.rd = 4'(i);
            tick();
            check("stream_valid", ro.valid, 1);
            check("stream_rd", ro.rd, 64'(i));
        end
        ri.valid = 1'b0;
        tick();
        check("stream_drain_valid", ro.valid, 0);
        check("stream_stall", stall_cnt, 0);

        // backpressure: 5 then 6 with out_ready low
        ro.ready = 1'b0;
        ri.valid = 1'b1;
        ri.rd = 4'd5;
        tick();
        check("bp_rd5", ro.rd, 5);
        check("bp_ready_after_first", ri.ready, SKID_BUILD ? 1 : 0);
        ri.rd = 4'd6;
        tick();
        check("bp_ready_after_second", ri.ready, 0);
`ifdef ID_EXE_SKID_EN
        ri.valid = 1'b0;
`endif
        tick();
        tick();
        check("bp_stall3", stall_cnt, 3);
        check("bp_hold_rd5", ro.rd, 5);
        ro.ready = 1'b1;
        #1;
        check("bp_ready_follow", ri.ready, SKID_BUILD ? 0 : 1);
        tick();
        check("bp_valid6", ro.valid, 1);
        check("bp_rd6", ro.rd, 6);
        check("bp_stall_hold", stall_cnt, 3);
        ri.valid = 1'b0;
        tick();
        check("bp_drain_valid", ro.valid, 0);

        // flush with a new instruction (9) on the same edge
        ro.ready = 1'b0;
        ri.valid = 1'b1;
        ri.rd = 4'd7;
        tick();
        ri.rd = 4'd8;
        tick();
        check("fl_rd7", ro.rd, 7);
        ri.rd = 4'd9;
        flush = 1'b1;
        tick();
        check("fl_valid_cleared", ro.valid, 0);
        flush = 1'b0;
        ri.valid = 1'b0;
        ro.ready = 1'b1;
        tick();
        check("fl_no_delivery", ro.valid, 0);
        check("fl_stall", stall_cnt, 4);
        check("fl_in_ready", ri.ready, 1);

        // full payload after flush
        ri.valid = 1'b1;
        ri.rd = 4'd3; ri.rs1 = 4'hA; ri.rs2 = 4'hF;
        ri.d1 = 32'h1234_5678; ri.d2 = 32'hCAFE_F00D;
        ri.imm_a = 19'h7FFFF; ri.imm_b = 26'h2AA_AAAA;
        tick();
        check("pay_valid", ro.valid, 1);
        check("pay_rd", ro.rd, 4'd3);
        check("pay_rs1", ro.rs1, 4'hA);
        check("pay_rs2", ro.rs2, 4'hF);
        check("pay_d1", ro.d1, 32'h1234_5678);
        check("pay_d2", ro.d2, 32'hCAFE_F00D);
        check("pay_imm_a", ro.imm_a, 19'h7FFFF);
        check("pay_imm_b", ro.imm_b, 26'h2AA_AAAA);
        ri.valid = 1'b0;
        tick();

        // wide instance: bit-exact wide fields and 4-bit counter saturation
        wi.valid = 1'b1;
        wi.rd = 4'd2;
        wi.d2 = 64'h0123_4567_89AB_CDEF;
        wi.imm_b = 30'h3FFF_FFFF;
        tick();
        check("w_valid", wo.valid, 1);
        check("w_d2", wo.d2, 64'h0123_4567_89AB_CDEF);
        check("w_imm_b", wo.imm_b, 30'h3FFF_FFFF);
        wi.valid = 1'b0;
        repeat (14) tick();
        check("w_stall14", stall_cnt_w, 4'hE);
        tick();
        check("w_stall15", stall_cnt_w, 4'hF);
        repeat (5) tick();
        check("w_stall20_sat", stall_cnt_w, 4'hF);
        check("w_d2_held", wo.d2, 64'h0123_4567_89AB_CDEF);
        wo.ready = 1'b1;
        tick();
        check("w_drain_valid", wo.valid, 0);
        check("w_stall_kept", stall_cnt_w, 4'hF);

        // asynchronous reset mid-cycle while FULL
        ro.ready = 1'b0;
        ri.valid = 1'b1;
        ri.d1 = 32'hDEAD_BEEF;
        tick();
        check("ar_d1_loaded", ro.d1, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", ro.valid, 0);
        check("ar_d1", ro.d1, 0);
        check("ar_in_ready", ri.ready, 1);
        check("ar_stall", stall_cnt, 0);
        check("ar_w_stall", stall_cnt_w, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
